// File: rtl/guess_game_sequencer.sv
// Number-guessing game sequencer: draws a target from a free-running LFSR, scores
// player guesses and drives the match/not_match inputs of the RGB LED controller.
//
// state      | meaning
// IDLE       | waiting for start, LED blue
// GEN        | one cycle: latch target from LFSR, reload tries
// WAIT_GUESS | guess_ready=1, waiting for a guess strobe
// SHOW_MATCH | green for DISPLAY_CYCLES cycles, then score and return to IDLE
// SHOW_MISS  | red for DISPLAY_CYCLES cycles, then retry or game over
// GAME_OVER  | red held until start begins a new round
module guess_game_sequencer #(
    parameter int         WIDTH          = 4,
    parameter int         DISPLAY_CYCLES = 4,
    parameter int         MAX_TRIES      = 3,
    parameter logic [7:0] LFSR_SEED      = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] guess,
    input  logic             guess_valid,
    output logic             guess_ready,
    output logic             match,
    output logic             not_match,
    output logic [3:0]       tries_left,
    output logic [7:0]       score,
    output logic [WIDTH-1:0] target
);

    localparam int CW = $clog2(DISPLAY_CYCLES + 1);
    localparam logic [CW-1:0] DISP_LAST = CW'(DISPLAY_CYCLES - 1);
    localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        WAIT_GUESS,
        SHOW_MATCH,
        SHOW_MISS,
        GAME_OVER
    } state_t;

    state_t        state;
    logic [7:0]    lfsr;
    logic [CW-1:0] disp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
        end
    end

    // Outputs are set on the edge that enters each state so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            disp_cnt    <= '0;
            guess_ready <= 1'b0;
            match       <= 1'b0;
            not_match   <= 1'b0;
            tries_left  <= 4'd0;
            score       <= 8'd0;
            target      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= GEN;
                    end
                end
                GEN: begin
                    target      <= lfsr[WIDTH-1:0];
                    tries_left  <= TRIES_INIT;
                    guess_ready <= 1'b1;
                    state       <= WAIT_GUESS;
                end
                WAIT_GUESS: begin
                    if (guess_valid) begin
                        guess_ready <= 1'b0;
                        disp_cnt    <= '0;
                        if (guess == target) begin
                            match <= 1'b1;
                            state <= SHOW_MATCH;
                        end else begin
                            not_match  <= 1'b1;
                            tries_left <= (tries_left != 4'd0) ? tries_left - 4'd1 : 4'd0;
                            state      <= SHOW_MISS;
                        end
                    end
                end
                SHOW_MATCH: begin
                    if (disp_cnt == DISP_LAST) begin
                        match <= 1'b0;
                        score <= (score == 8'hFF) ? 8'hFF : score + 8'd1;
                        state <= IDLE;
                    end else begin
                        disp_cnt <= disp_cnt + 1'b1;
                    end
                end
                SHOW_MISS: begin
                    if (disp_cnt == DISP_LAST) begin
                        if (tries_left == 4'd0) begin
                            state <= GAME_OVER;
                        end else begin
                            not_match   <= 1'b0;
                            guess_ready <= 1'b1;
                            state       <= WAIT_GUESS;
                        end
                    end else begin
                        disp_cnt <= disp_cnt + 1'b1;
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        not_match <= 1'b0;
                        state     <= GEN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
